// File: rtl/add_seq_n.sv
// add_seq_n: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock through a registered carry
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : operation request, sampled only while busy=0
//   sub          : 0 = x + y + cy_in, 1 = x - y
//   x, y         : operands, latched with start
//   cy_in        : carry-in for add mode, ignored when subtracting
//   s            : registered result, valid from done until the next accepted start
//   cy_out, ovf  : carry out of the MSB (1 = no borrow when subtracting), signed overflow
//   busy, done   : operation in progress, one-cycle completion pulse
module add_seq_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cy_in,
    output logic [WIDTH-1:0] s,
    output logic             cy_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cy;
    logic             r_ovf;
    logic             r_done;
    logic [CHUNK:0]   w_sum;
    logic             w_last;

    assign w_sum  = {1'b0, r_a[r_cnt*CHUNK +: CHUNK]} + {1'b0, r_b[r_cnt*CHUNK +: CHUNK]} + (CHUNK+1)'(r_carry);
    assign w_last = r_cnt == CW'(N - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cy    <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_a     <= x;
                    r_b     <= sub ? ~y : y;
                    r_carry <= sub | cy_in;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
            end else begin
                r_s[r_cnt*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
                r_carry <= w_sum[CHUNK];
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cy    <= w_sum[CHUNK];
                    // carry into the MSB is a^b^sum at that bit; overflow is it xor carry out
                    r_ovf   <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[CHUNK-1] ^ w_sum[CHUNK];
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
            end
        end
    end

    assign s      = r_s;
    assign cy_out = r_cy;
    assign ovf    = r_ovf;
    assign busy   = r_state == RUN;
    assign done   = r_done;
endmodule

// File: doc/add_seq_n.md
# add_seq_n

Parametrised multi-cycle adder/subtractor, the chunked successor of the 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock through a registered carry, so wide operands cost no long combinational carry chain. It sits in the datapath wherever wide arithmetic is needed and single-cycle timing cannot be met. A start/busy/done handshake frames each operation, and the block reports carry-out and signed overflow.

## Interface
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits added per clock. N = WIDTH/CHUNK chunk cycles per operation.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  operation request; sampled only while busy=0.
- sub  input  1  0 = add, 1 = subtract (x - y); sampled with start.
- x  input  WIDTH  operand A; sampled with start.
- y  input  WIDTH  operand B; sampled with start.
- cy_in  input  1  carry-in for add mode; ignored in subtract mode.
- s  output  WIDTH  registered result.
- cy_out  output  1  carry out of bit WIDTH-1. In subtract mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow of the result.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse when s, cy_out and ovf become valid.

## Operation
- Two-state FSM: IDLE and RUN, plus a chunk counter of width clog2(N), minimum 1 bit.
- **IDLE.** When start=1 at a clock edge:
  - latch a = x;
  - latch b = sub ? ~y : y;
  - set carry = sub ? 1 : cy_in;
  - clear the counter;
  - go to RUN.
- **RUN, chunk cycle i = 0..N-1:**
  - compute {c, r} = a[i*CHUNK +: CHUNK] + b[i*CHUNK +: CHUNK] + carry, as a CHUNK+1-bit sum;
  - write s[i*CHUNK +: CHUNK] = r;
  - carry <= c.
- **Last chunk (i = N-1):**
  - cy_out <= c;
  - ovf <= a[WIDTH-1] ^ b[WIDTH-1] ^ r[CHUNK-1] ^ c, i.e. carry into the MSB xor carry out;
  - done <= 1;
  - return to IDLE.
- Arithmetic is modulo 2^WIDTH. s equals the low WIDTH bits of a + b + initial carry.
- start while busy=1 is ignored. No queuing; x, y, sub and cy_in are not re-sampled.
- s, cy_out and ovf hold their values from done until the next accepted start. They may show partial-result bits while busy=1; s is valid only from done onward.
- Reset:
  - values after reset: s=0, cy_out=0, ovf=0, busy=0, done=0, FSM in IDLE;
  - reset during RUN aborts the operation; no done is produced;
  - rst has priority over start in the same cycle.

## Timing
- start sampled high at edge k with busy=0:
  - busy=1 from after edge k;
  - chunk i is processed at edge k+1+i.
- Edge k+N:
  - busy=0, done=1, and s, cy_out and ovf are valid.
- Latency: N cycles from the start edge to done. With WIDTH=16 and CHUNK=4, that is 4 cycles.
- done is high for exactly one cycle.
- busy is low in the done cycle. A start in that cycle, at edge k+N+1, is accepted, giving back-to-back throughput of one operation per N+1 cycles.
- CHUNK = WIDTH (N=1) is legal: busy is high for one cycle and done follows one edge after start.

## Test plan
- **Reset values.** Assert rst for 2 cycles, start=1 held -> s=0x0000, cy_out=0, ovf=0, busy=0, done=0, and no operation started.
- **Add with carry-in.** WIDTH=16, CHUNK=4; x=0x1234, y=0x4321, cy_in=1, sub=0 -> s=0x5556, cy_out=0, ovf=0. done pulses exactly 4 cycles after the start edge, and busy is high for those 4 cycles.
- **Carry wrap and signed overflow.**
  - x=0xFFFF, y=0x0001, cy_in=0 -> s=0x0000, cy_out=1, ovf=0.
  - x=0x7FFF, y=0x0001 -> s=0x8000, cy_out=0, ovf=1.
- **Subtract.**
  - sub=1, x=0x0005, y=0x0007, cy_in=1 (must be ignored) -> s=0xFFFE, cy_out=0, ovf=0.
  - x=0x8000, y=0x0001 -> s=0x7FFF, cy_out=1, ovf=1.
- **Handshake edges.**
  - Pulse start with new operands in the middle of busy -> ignored; the original result is unchanged.
  - Assert start in the done cycle with x=0x0001, y=0x0002 -> accepted; the next done gives s=0x0003.
- **Reset mid-operation.** Assert rst at chunk cycle 2 -> the next cycle shows busy=0, s=0, and no done pulse. A subsequent normal start completes correctly.
